// File: rtl/rv_iopmp_entry_table_if.sv
// Bus bundle for the IOPMP entry table: matching-logic read port, register
// programming port and the lock boundary.
interface rv_iopmp_entry_table_if #(
    parameter int unsigned NUMBER_ENTRIES = 8
);
    localparam int unsigned IDX_W = $clog2(NUMBER_ENTRIES);

    logic             read_enable_i;
    logic [IDX_W-1:0] read_addr_i;
    logic [63:0]      entry_data_o;
    logic             entry_valid_o;

    logic             reg_req_i;
    logic             reg_we_i;
    logic [IDX_W+1:0] reg_addr_i;
    logic [31:0]      reg_wdata_i;
    logic             reg_gnt_o;
    logic             reg_rvalid_o;
    logic [31:0]      reg_rdata_o;
    logic             reg_err_o;

    logic [IDX_W:0]   entry_lock_i;

    modport master (
        output read_enable_i, read_addr_i, reg_req_i, reg_we_i, reg_addr_i,
               reg_wdata_i, entry_lock_i,
        input  entry_data_o, entry_valid_o, reg_gnt_o, reg_rvalid_o,
               reg_rdata_o, reg_err_o
    );

    modport slave (
        input  read_enable_i, read_addr_i, reg_req_i, reg_we_i, reg_addr_i,
               reg_wdata_i, entry_lock_i,
        output entry_data_o, entry_valid_o, reg_gnt_o, reg_rvalid_o,
               reg_rdata_o, reg_err_o
    );
endinterface

// File: rtl/rv_iopmp_entry_table.sv
// Flop-based IOPMP entry storage with a one-cycle matching-logic read port and a
// 32-bit register port for ADDR/ADDRH/CFG words; the matching read always wins.
module rv_iopmp_entry_table #(
    parameter int unsigned NUMBER_ENTRIES = 8,
    parameter int unsigned ENTRY_ADDR_LEN = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rv_iopmp_entry_table_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUMBER_ENTRIES);

    logic [ENTRY_ADDR_LEN-1:0] addr_q [NUMBER_ENTRIES];
    logic [4:0]                cfg_q  [NUMBER_ENTRIES];

    logic [IDX_W-1:0] reg_idx_p0;
    logic [1:0]       reg_word_p0;
    logic             reg_locked_p0;
    logic             gnt_p0;
    logic             wr_en_p0;
    logic [63:0]      reg_addr64_p0;
    logic [63:0]      wr_lo64_p0;
    logic [63:0]      wr_hi64_p0;
    logic [31:0]      rdata_p0;

    logic [63:0]      entry_data_p1;
    logic             entry_vld_p1;
    logic             rsp_vld_p1;
    logic [31:0]      rsp_rdata_p1;
    logic             rsp_err_p1;

    // Write-only without read is not a legal permission, so w is dropped.
    function automatic logic [4:0] cfg_warl(input logic [31:0] wdata);
        logic [4:0] c;
        c = wdata[4:0];
        if (c[1] && !c[0]) c[1] = 1'b0;
        return c;
    endfunction

    function automatic logic [63:0] pack_entry(input logic [ENTRY_ADDR_LEN-1:0] a,
                                               input logic [4:0] c);
        logic [63:0] e;
        e = 64'(a);
        e[63:56] = {3'b000, c};
        return e;
    endfunction

    // Stage p0: arbitration, decode and register-port read mux
    assign reg_idx_p0    = bus.reg_addr_i[IDX_W+1:2];
    assign reg_word_p0   = bus.reg_addr_i[1:0];
    assign reg_locked_p0 = {1'b0, reg_idx_p0} < bus.entry_lock_i;
    assign gnt_p0        = bus.reg_req_i & ~bus.read_enable_i & ~rst_i;
    assign wr_en_p0      = gnt_p0 & bus.reg_we_i & ~reg_locked_p0;
    assign reg_addr64_p0 = 64'(addr_q[reg_idx_p0]);
    // Merge the new half into the 64-bit view; truncation drops unstored bits.
    assign wr_lo64_p0    = {reg_addr64_p0[63:32], bus.reg_wdata_i};
    assign wr_hi64_p0    = {bus.reg_wdata_i, reg_addr64_p0[31:0]};

    always_comb begin
        rdata_p0 = '0;
        if (!bus.reg_we_i) begin
            case (reg_word_p0)
                2'd0:    rdata_p0 = reg_addr64_p0[31:0];
                2'd1:    rdata_p0 = reg_addr64_p0[63:32];
                2'd2:    rdata_p0 = {27'b0, cfg_q[reg_idx_p0]};
                default: rdata_p0 = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '{default: '0};
            cfg_q  <= '{default: '0};
        end else if (wr_en_p0) begin
            case (reg_word_p0)
                2'd0:    addr_q[reg_idx_p0] <= wr_lo64_p0[ENTRY_ADDR_LEN-1:0];
                2'd1:    addr_q[reg_idx_p0] <= wr_hi64_p0[ENTRY_ADDR_LEN-1:0];
                2'd2:    cfg_q[reg_idx_p0]  <= cfg_warl(bus.reg_wdata_i);
                default: ;
            endcase
        end
    end

    // Stage p1: registered entry read result and register response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_data_p1 <= '0;
            entry_vld_p1  <= 1'b0;
        end else begin
            entry_vld_p1 <= bus.read_enable_i;
            if (bus.read_enable_i)
                entry_data_p1 <= pack_entry(addr_q[bus.read_addr_i], cfg_q[bus.read_addr_i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_vld_p1   <= 1'b0;
            rsp_rdata_p1 <= '0;
            rsp_err_p1   <= 1'b0;
        end else begin
            rsp_vld_p1   <= gnt_p0;
            rsp_rdata_p1 <= gnt_p0 ? rdata_p0 : '0;
            rsp_err_p1   <= gnt_p0 & bus.reg_we_i & reg_locked_p0;
        end
    end

    assign bus.reg_gnt_o     = gnt_p0;
    assign bus.entry_data_o  = entry_data_p1;
    assign bus.entry_valid_o = entry_vld_p1;
    assign bus.reg_rvalid_o  = rsp_vld_p1;
    assign bus.reg_rdata_o   = rsp_rdata_p1;
    assign bus.reg_err_o     = rsp_err_p1;
endmodule
